// File: rtl/ysyx_22040750_ifu.sv
// ysyx_22040750_ifu -- instruction fetch unit
//
// Keeps one instruction fetch in flight at a time. It issues a doubleword
// read, waits for the response, and picks the 32-bit word selected by pc[2].
// The word is held in the IF/ID register until decode consumes it. The unit
// then waits for the next PC. A redirect (I_flush with I_pc_valid) can arrive
// in any state. Any fetch already started runs to completion, and its data is
// thrown away.
//
// Ports:
//   I_clk, I_rst              clock and synchronous active-high reset
//   I_pc_valid, I_dnpc        next PC offered by the next-PC stage
//   I_flush                   redirect, only meaningful with I_pc_valid
//   O_pc_ready                IFU takes I_dnpc this cycle
//   O_imem_req_*, I_imem_*    request/response handshakes to instruction memory
//   O_IF_ID_*                 IF/ID register contents presented to decode
//   I_ID_ready                decode consumes the IF/ID entry
module ysyx_22040750_ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_pc_valid,
  input  logic [31:0] I_dnpc,
  input  logic        I_flush,
  output logic        O_pc_ready,
  output logic        O_imem_req_valid,
  output logic [31:0] O_imem_req_addr,
  input  logic        I_imem_req_ready,
  input  logic        I_imem_resp_valid,
  input  logic [63:0] I_imem_resp_data,
  output logic        O_imem_resp_ready,
  output logic        O_IF_ID_valid,
  output logic [31:0] O_IF_ID_pc,
  output logic [31:0] O_IF_ID_snpc,
  output logic [31:0] O_IF_ID_inst,
  output logic        O_IF_ID_misalign,
  input  logic        I_ID_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_OUT  = 2'd2,
    S_NPC  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic [31:0] req_addr_hold;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_snpc;
  logic [31:0] if_id_inst;
  logic        if_id_misalign;

  logic flush_now;
  logic misaligned;
  logic req_pending;
  logic req_fire;
  logic resp_fire;

  // Decode the handshake conditions. drop=1 in S_REQ means a request was
  // already on the bus when a redirect arrived. That request has to finish
  // with its original address, so it is still issued even if the new pc is
  // misaligned.
  always_comb begin
    flush_now   = I_flush & I_pc_valid;
    misaligned  = (pc[1:0] != 2'b00);
    req_pending = (state == S_REQ) && (drop || !misaligned);
    req_fire    = req_pending && I_imem_req_ready;
    resp_fire   = (state == S_RESP) && I_imem_resp_valid;
  end

  // Drive the outputs. The handshake outputs are forced low while reset is
  // held, because state is only cleared at the first reset edge.
  always_comb begin
    O_imem_req_valid  = !I_rst && req_pending;
    O_imem_req_addr   = drop ? req_addr_hold : {pc[31:3], 3'b000};
    O_imem_resp_ready = !I_rst && (state == S_RESP);
    O_IF_ID_valid     = !I_rst && (state == S_OUT);
    O_pc_ready        = !I_rst && ((state == S_NPC) || I_flush);
    O_IF_ID_pc        = if_id_pc;
    O_IF_ID_snpc      = if_id_snpc;
    O_IF_ID_inst      = if_id_inst;
    O_IF_ID_misalign  = if_id_misalign;
  end

  // Fetch FSM. A redirect always updates pc at once. What happens to a fetch
  // in flight depends on how far it has gone: an unaccepted request is
  // completed and marked for dropping, and a response that is still awaited
  // is marked for dropping. A held IF/ID entry is simply abandoned.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      req_addr_hold  <= 32'h0;
      if_id_pc       <= 32'h0;
      if_id_snpc     <= 32'h0;
      if_id_inst     <= 32'h0;
      if_id_misalign <= 1'b0;
    end else begin
      if (flush_now) begin
        pc <= I_dnpc;
      end
      case (state)
        S_REQ: begin
          if (req_pending) begin
            if (req_fire) begin
              state <= S_RESP;
              if (flush_now) begin
                drop <= 1'b1;
              end
            end else if (flush_now && !drop) begin
              // Capture the old address so the bus sees no change.
              drop          <= 1'b1;
              req_addr_hold <= {pc[31:3], 3'b000};
            end
          end else if (!flush_now) begin
            // Misaligned pc: report it to decode without touching memory.
            state          <= S_OUT;
            if_id_pc       <= pc;
            if_id_snpc     <= pc + 32'd4;
            if_id_inst     <= 32'h0;
            if_id_misalign <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_fire) begin
            if (drop || flush_now) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              state          <= S_OUT;
              if_id_pc       <= pc;
              if_id_snpc     <= pc + 32'd4;
              if_id_inst     <= pc[2] ? I_imem_resp_data[63:32] : I_imem_resp_data[31:0];
              if_id_misalign <= 1'b0;
            end
          end else if (flush_now) begin
            drop <= 1'b1;
          end
        end
        S_OUT: begin
          if (flush_now) begin
            state <= S_REQ;
          end else if (I_ID_ready) begin
            state <= S_NPC;
          end
        end
        S_NPC: begin
          if (I_pc_valid) begin
            pc    <= I_dnpc;
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// tb_ysyx_22040750_ifu -- directed self-checking bench for the fetch unit
//
// Drives inputs on the falling edge and samples outputs 1 time unit later,
// well away from the rising edge where state updates.
module tb_ysyx_22040750_ifu;

  logic        I_clk;
  logic        I_rst;
  logic        I_pc_valid;
  logic [31:0] I_dnpc;
  logic        I_flush;
  logic        O_pc_ready;
  logic        O_imem_req_valid;
  logic [31:0] O_imem_req_addr;
  logic        I_imem_req_ready;
  logic        I_imem_resp_valid;
  logic [63:0] I_imem_resp_data;
  logic        O_imem_resp_ready;
  logic        O_IF_ID_valid;
  logic [31:0] O_IF_ID_pc;
  logic [31:0] O_IF_ID_snpc;
  logic [31:0] O_IF_ID_inst;
  logic        O_IF_ID_misalign;
  logic        I_ID_ready;

  int errorCount = 0;
  int checkCount = 0;

  ysyx_22040750_ifu #(.RESET_PC(32'h80000000)) dut (
    .I_clk             (I_clk),
    .I_rst             (I_rst),
    .I_pc_valid        (I_pc_valid),
    .I_dnpc            (I_dnpc),
    .I_flush           (I_flush),
    .O_pc_ready        (O_pc_ready),
    .O_imem_req_valid  (O_imem_req_valid),
    .O_imem_req_addr   (O_imem_req_addr),
    .I_imem_req_ready  (I_imem_req_ready),
    .I_imem_resp_valid (I_imem_resp_valid),
    .I_imem_resp_data  (I_imem_resp_data),
    .O_imem_resp_ready (O_imem_resp_ready),
    .O_IF_ID_valid     (O_IF_ID_valid),
    .O_IF_ID_pc        (O_IF_ID_pc),
    .O_IF_ID_snpc      (O_IF_ID_snpc),
    .O_IF_ID_inst      (O_IF_ID_inst),
    .O_IF_ID_misalign  (O_IF_ID_misalign),
    .I_ID_ready        (I_ID_ready)
  );

  // 10-unit clock. Rising edges fall at 5, 15, 25 and so on.
  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  // Compare one observed value with its expected value and log any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive every input for the coming cycle, then let the outputs settle.
  task automatic applyStimulus(input logic rst, input logic pv, input logic [31:0] dnpc,
                               input logic fl, input logic rqr, input logic rsv,
                               input logic [63:0] data, input logic idr);
    I_rst             = rst;
    I_pc_valid        = pv;
    I_dnpc            = dnpc;
    I_flush           = fl;
    I_imem_req_ready  = rqr;
    I_imem_resp_valid = rsv;
    I_imem_resp_data  = data;
    I_ID_ready        = idr;
    #1;
  endtask

  // Move forward one rising edge, then return to the next falling edge.
  task automatic tick();
    @(posedge I_clk);
    @(negedge I_clk);
  endtask

  // Directed scenario sequence. Every expected value below was worked out by hand.
  initial begin
    @(negedge I_clk);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_req_valid", O_imem_req_valid, 0);
    checkOutput("rst_if_id_valid", O_IF_ID_valid, 0);
    checkOutput("rst_resp_ready", O_imem_resp_ready, 0);
    checkOutput("rst_pc_ready", O_pc_ready, 0);
    checkOutput("rst_if_id_pc", O_IF_ID_pc, 0);
    checkOutput("rst_if_id_inst", O_IF_ID_inst, 0);

    // Basic fetch: the lower word at the reset PC.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("basic_req_valid", O_imem_req_valid, 1);
    checkOutput("basic_req_addr", O_imem_req_addr, 32'h80000000);
    checkOutput("basic_pc_ready", O_pc_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h00000013_00100093, 0);
    checkOutput("basic_resp_ready", O_imem_resp_ready, 1);
    checkOutput("basic_req_idle", O_imem_req_valid, 0);
    tick();
    checkOutput("basic_valid", O_IF_ID_valid, 1);
    checkOutput("basic_inst", O_IF_ID_inst, 32'h00100093);
    checkOutput("basic_pc", O_IF_ID_pc, 32'h80000000);
    checkOutput("basic_snpc", O_IF_ID_snpc, 32'h80000004);
    checkOutput("basic_misalign", O_IF_ID_misalign, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("npc_pc_ready", O_pc_ready, 1);
    checkOutput("npc_valid", O_IF_ID_valid, 0);

    // Upper word: the same doubleword, with pc[2] set.
    applyStimulus(0, 1, 32'h80000004, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("upper_req_addr", O_imem_req_addr, 32'h80000000);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h00000013_00100093, 0);
    tick();
    checkOutput("upper_inst", O_IF_ID_inst, 32'h00000013);
    checkOutput("upper_pc", O_IF_ID_pc, 32'h80000004);
    checkOutput("upper_snpc", O_IF_ID_snpc, 32'h80000008);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    // Backpressure on both the request and the IF/ID handshakes.
    applyStimulus(0, 1, 32'h80000008, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("bp_req_valid", O_imem_req_valid, 1);
      checkOutput("bp_req_addr", O_imem_req_addr, 32'h80000008);
      checkOutput("bp_pc_ready_req", O_pc_ready, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 64'hAAAAAAAA_BBBBBBBB, 0);
    checkOutput("bp_pc_ready_resp", O_pc_ready, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("bp_out_valid", O_IF_ID_valid, 1);
      checkOutput("bp_out_inst", O_IF_ID_inst, 32'hBBBBBBBB);
      checkOutput("bp_out_pc", O_IF_ID_pc, 32'h80000008);
      checkOutput("bp_pc_ready_out", O_pc_ready, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    // Flush while the response is outstanding.
    applyStimulus(0, 1, 32'h80000010, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("fl_req_addr_old", O_imem_req_addr, 32'h80000010);
    tick();
    applyStimulus(0, 1, 32'h80001000, 1, 0, 0, 0, 0);
    checkOutput("fl_pc_ready", O_pc_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 64'hDEADBEEF_CAFEF00D, 0);
    checkOutput("fl_resp_ready", O_imem_resp_ready, 1);
    checkOutput("fl_no_valid_wait", O_IF_ID_valid, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_dropped_valid", O_IF_ID_valid, 0);
    checkOutput("fl_new_req_valid", O_imem_req_valid, 1);
    checkOutput("fl_new_req_addr", O_imem_req_addr, 32'h80001000);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h11111111_22222222, 0);
    tick();
    checkOutput("fl_new_inst", O_IF_ID_inst, 32'h22222222);
    checkOutput("fl_new_pc", O_IF_ID_pc, 32'h80001000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    // Misaligned PC: reported to decode without a memory request.
    applyStimulus(0, 1, 32'h80000002, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mis_no_req", O_imem_req_valid, 0);
    tick();
    checkOutput("mis_valid", O_IF_ID_valid, 1);
    checkOutput("mis_flag", O_IF_ID_misalign, 1);
    checkOutput("mis_inst", O_IF_ID_inst, 0);
    checkOutput("mis_pc", O_IF_ID_pc, 32'h80000002);
    checkOutput("mis_snpc", O_IF_ID_snpc, 32'h80000006);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    // A flush without I_pc_valid is ignored, so the unit stays in the next-PC wait.
    applyStimulus(0, 0, 32'h80000100, 1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("nopv_pc_ready", O_pc_ready, 1);
    checkOutput("nopv_no_req", O_imem_req_valid, 0);

    // Wraparound: snpc for 32'hFFFFFFFC is zero.
    applyStimulus(0, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("wrap_req_addr", O_imem_req_addr, 32'hFFFFFFF8);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h12345678_9ABCDEF0, 0);
    tick();
    checkOutput("wrap_inst", O_IF_ID_inst, 32'h12345678);
    checkOutput("wrap_snpc", O_IF_ID_snpc, 32'h00000000);

    // A flush wins over I_ID_ready while an entry is held.
    applyStimulus(0, 1, 32'h80000040, 1, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("prio_valid", O_IF_ID_valid, 0);
    checkOutput("prio_req_valid", O_imem_req_valid, 1);
    checkOutput("prio_req_addr", O_imem_req_addr, 32'h80000040);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    tick();

    // Reset while a response is awaited. A late response must be ignored.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rmid_req_valid", O_imem_req_valid, 0);
    checkOutput("rmid_resp_ready", O_imem_resp_ready, 0);
    tick();
    checkOutput("rmid_if_id_pc", O_IF_ID_pc, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 64'hFFFFFFFF_FFFFFFFF, 0);
    checkOutput("rmid_new_req_valid", O_imem_req_valid, 1);
    checkOutput("rmid_new_req_addr", O_imem_req_addr, 32'h80000000);
    checkOutput("rmid_resp_ignored", O_imem_resp_ready, 0);
    tick();
    checkOutput("rmid_no_valid", O_IF_ID_valid, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h00000000_00000073, 0);
    tick();
    checkOutput("rmid_inst", O_IF_ID_inst, 32'h00000073);
    checkOutput("rmid_pc", O_IF_ID_pc, 32'h80000000);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
